alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one 64-bit Y86 ALU (add/sub/and/xor with ZF/SF/OF flags) between two requesters.
  - Requester 0: execute stage, may update condition codes.
  - Requester 1: auxiliary unit, e.g. address/microcode sequencer; never touches CC.
- Round-robin arbitration, valid/ready handshakes, a registered single-issue ALU, and the architectural condition-code register.
- Sits between decode/execute control and the ALU datapath; cc_out feeds branch/cmov condition evaluation.

Parameters:
- WIDTH, 64, operand/result width in bits.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester accept; at most one bit high.
- req0_a  input  WIDTH  requester 0 operand A (aluA).
- req0_b  input  WIDTH  requester 0 operand B (aluB).
- req0_fun  input  2  requester 0 ALU function.
- req0_setcc  input  1  requester 0: load CC from this op's flags.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_fun  input  2  requester 1 ALU function.
- resp_valid  output  2  per-requester response valid.
- resp_ready  input  2  per-requester response accept.
- resp_data  output  WIDTH  ALU result (valE).
- resp_flags  output  3  flags of this op: [0]=ZF, [1]=SF, [2]=OF.
- cc_out  output  3  architectural CC register, same bit order.

Behaviour:
- ALU functions:
  - 00: A+B.
  - 01: B-A.
  - 10: A&B.
  - 11: A^B.
  - Result width WIDTH, carry-out discarded.
- Flags:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - OF for add = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - OF for sub = (B[msb]!=A[msb]) && (R[msb]!=B[msb]).
  - OF for and/xor = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant g: the single valid requester, or if both are valid, the requester != last_grant.
  - req_ready[g] is combinational, high only in IDLE for the granted requester.
  - On handshake: capture operands, fun, setcc (forced 0 for g=1) and g, then go to EXEC.
- EXEC (exactly 1 cycle):
  - Register result and flags into resp_data/resp_flags.
  - If setcc is captured, cc_out <= flags on the same edge.
  - Go to RESP.
- RESP:
  - resp_valid[g] high; resp_data and resp_flags held stable.
  - On resp_ready[g]: go to IDLE, last_grant <= g.
  - No new grant while in RESP.
- Latency and throughput:
  - Handshake at edge T gives resp_valid from edge T+1.
  - Best-case throughput is 1 op per 3 cycles.
- Requester-side rules:
  - Operands need be stable only in the handshake cycle.
  - req_valid may drop without a handshake; no state change results.
  - resp_ready of the non-granted requester is ignored.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
  - resp_valid = 00, req_ready = 00.
  - resp_data = 0, resp_flags = 000, cc_out = 000.
- Reset asserted mid-operation: in-flight op aborted with no response; CC returns to 000.

Optional Feature:
- Macro: ALU_LOCK_EN.
- When defined:
  - Adds input port req_lock (2 bits).
  - If the granted requester's req_lock bit is high at the response handshake, it keeps priority at the next IDLE arbitration whenever its req_valid is high.
  - Lock releases on the first response handshake with the lock bit low.
  - A locked requester with no valid request does not block the other requester.
- When undefined: port absent; pure round-robin.

Test Plan:
- Reset and idle: after rst_n release with no valid requests -> req_ready=00, resp_valid=00, cc_out=000 for 10 cycles.
- Add with setcc: req0 fun=00, a=5, b=7, setcc=1 -> resp_valid[0] one cycle after handshake, resp_data=12, resp_flags=000, cc_out=000.
- Sub giving zero: req0 fun=01, a=5, b=5, setcc=1 -> resp_data=0, flags=001, cc_out=001.
- Add overflow: a=b=0x7FFF_FFFF_FFFF_FFFF, setcc=1 -> resp_data=0xFFFF_FFFF_FFFF_FFFE, flags=110, cc_out=110.
- Requester 1 isolation and fairness:
  - Precondition: cc_out=110.
  - Both requesters continuously valid, req1 fun=11, a=b=all-ones.
  - Grants alternate 0,1,0,1.
  - Requester 1 responses: data=0, flags=001, cc_out unchanged at 110.
- Backpressure and reset:
  - resp_ready low 5 cycles -> resp_data/resp_flags stable, no new req_ready.
  - rst_n asserted while in RESP -> resp_valid=00 immediately, cc_out=000.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one registered 64-bit Y86 ALU (add/sub/and/xor with
// ZF/SF/OF) shared by two requesters under round-robin arbitration.
// Requester 0 may load the architectural condition codes; requester 1 never does.
// Optional feature macro ALU_LOCK_EN: adds req_lock so that a requester can keep
// priority across consecutive operations.
module alu_share_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_fun,
   input  logic             req0_setcc,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_fun,
`ifdef ALU_LOCK_EN
   input  logic [1:0]       req_lock,
`endif
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [2:0]       resp_flags,
   output logic [2:0]       cc_out
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_reg, state_next;
   logic               last_grant_reg;
   logic               grant_reg;
   logic [WIDTH-1:0]   a_reg, b_reg;
   logic [1:0]         fun_reg;
   logic               setcc_reg;

   logic               arb_grant;
   logic               req_hs;
   logic               resp_hs;
   logic               lock_keep;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_of;
   logic [2:0]         alu_flags;

`ifdef ALU_LOCK_EN
   assign lock_keep = req_lock[grant_reg];
`else
   assign lock_keep = 1'b0;
`endif

   // Arbitration: a lone valid requester wins; on a tie the one not served last wins.
   always_comb begin
      arb_grant = 1'b0;
      case (req_valid)
         2'b01:   arb_grant = 1'b0;
         2'b10:   arb_grant = 1'b1;
         2'b11:   arb_grant = ~last_grant_reg;
         default: arb_grant = 1'b0;
      endcase
   end

   // Next-state logic and handshake outputs of the issue/execute/respond sequence.
   always_comb begin
      state_next = state_reg;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      req_hs     = 1'b0;
      resp_hs    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid != 2'b00) begin
               req_ready  = arb_grant ? 2'b10 : 2'b01;
               req_hs     = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            resp_valid = grant_reg ? 2'b10 : 2'b01;
            if (resp_ready[grant_reg]) begin
               resp_hs    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Nothing is offered while reset is held, even though the state reads IDLE.
      if (!rst_n) begin
         req_ready = 2'b00;
      end
   end

   // State register and round-robin history; a held lock flips the history so
   // the current owner also wins the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (resp_hs) begin
            last_grant_reg <= lock_keep ? ~grant_reg : grant_reg;
         end
      end
   end

   // Operand capture on the request handshake; requester 1 can never set CC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         fun_reg   <= 2'b00;
         setcc_reg <= 1'b0;
      end else if (req_hs) begin
         grant_reg <= arb_grant;
         a_reg     <= arb_grant ? req1_a   : req0_a;
         b_reg     <= arb_grant ? req1_b   : req0_b;
         fun_reg   <= arb_grant ? req1_fun : req0_fun;
         setcc_reg <= arb_grant ? 1'b0     : req0_setcc;
      end
   end

   // ALU: result wraps to WIDTH bits; flags are {OF, SF, ZF}.
   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      case (fun_reg)
         2'b00: begin
            alu_res = a_reg + b_reg;
            alu_of  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
         end
         2'b01: begin
            alu_res = b_reg - a_reg;
            alu_of  = (b_reg[WIDTH-1] != a_reg[WIDTH-1]) && (alu_res[WIDTH-1] != b_reg[WIDTH-1]);
         end
         2'b10:   alu_res = a_reg & b_reg;
         default: alu_res = a_reg ^ b_reg;
      endcase
      alu_flags = {alu_of, alu_res[WIDTH-1], (alu_res == '0)};
   end

   // Result, per-op flags and architectural CC are all loaded on the EXEC edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_data  <= '0;
         resp_flags <= 3'b000;
         cc_out     <= 3'b000;
      end else if (state_reg == EXEC) begin
         resp_data  <= alu_res;
         resp_flags <= alu_flags;
         if (setcc_reg) begin
            cc_out <= alu_flags;
         end
      end
   end

endmodule
